draw_scheduler: RTL and testbench

Frame-level sequencer for the object-drawing datapath. Each frame tick, it runs an erase pass over the objects drawn last frame, then a draw pass over the currently valid objects. For each object it drives the object-select code, issues a start pulse, and waits for the datapath's completion flag. It sits between the game-logic frame timer and the display datapath, and it owns the `plot` qualifier toward the VGA adapter.

---
 rtl/draw_scheduler.sv | 91 +++++++++
 tb/tb_draw_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// draw_scheduler: per-frame erase-then-draw sequencer driving the object datapath
module draw_scheduler #(
  parameter int NUM_OBJ = 5,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [NUM_OBJ-1:0] obj_valid,
  input  logic               obj_done,
  output logic [3:0]         control_signal,
  output logic               obj_start,
  output logic               erase,
  output logic               plot,
  output logic               busy,
  output logic               frame_done,
  output logic               timeout_err,
  output logic               overrun
);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {IDLE, SELECT, START, WAIT, FINISH} state_t;
  state_t state;
  logic [3:0] idx;
  logic pass;
  logic [NUM_OBJ-1:0] cur_mask, prev_mask, act;
  logic [WW-1:0] wdog;
  logic hit, at_end, active;
  assign act = pass ? cur_mask : prev_mask;
  assign at_end = idx == 4'(NUM_OBJ);
  assign active = state == SELECT || state == START || state == WAIT;
  // mask bit for the index currently under examination
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) hit = (idx == 4'(i)) ? act[i] : hit;
  end
  // frame sequencer: erase pass over prev_mask, then draw pass over the snapshot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= 4'd0;
      pass        <= 1'b0;
      cur_mask    <= '0;
      prev_mask   <= '0;
      wdog        <= '0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (frame_tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (frame_tick) begin
          cur_mask <= obj_valid;
          idx      <= 4'd0;
          pass     <= 1'b0;
          state    <= SELECT;
        end
        SELECT: if (at_end) begin
          if (pass) state <= FINISH;
          else begin
            pass <= 1'b1;
            idx  <= 4'd0;
          end
        end else if (hit) state <= START;
        else idx <= idx + 4'd1;
        START: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          wdog <= wdog + 1'b1;
          if (obj_done || wdog == WW'(TIMEOUT)) begin
            timeout_err <= timeout_err | ~obj_done;
            idx         <= idx + 4'd1;
            state       <= SELECT;
          end
        end
        FINISH: begin
          prev_mask <= cur_mask;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Moore output decode from registered state
  assign control_signal = active ? idx : 4'd0;
  assign erase = active & ~pass;
  assign obj_start = state == START;
  assign plot = state == WAIT;
  assign busy = state != IDLE;
  assign frame_done = state == FINISH;
endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: table, hand-written and random frames checked against a frame-level model
module tb_draw_scheduler;
  localparam int N = 5;
  localparam int TO = 1023;
  logic clk, reset, frame_tick, obj_done;
  logic [N-1:0] obj_valid;
  logic [3:0] control_signal;
  logic obj_start, erase, plot, busy, frame_done, timeout_err, overrun;
  int nvec, nerr;
  int lat_tab[10];
  bit stray_en;
  logic [N-1:0] prev_m;
  bit exp_to, exp_ov;
  typedef struct {
    logic [N-1:0] valid;
    int lat;
    int len;
    int starts;
    int plots;
  } vec_t;
  vec_t tbl[5];

  draw_scheduler dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .obj_valid(obj_valid),
    .obj_done(obj_done), .control_signal(control_signal), .obj_start(obj_start),
    .erase(erase), .plot(plot), .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    frame_tick = 1'b0;
    obj_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    prev_m = '0;
    exp_to = 0;
    exp_ov = 0;
  endtask

  // Runs one frame; the model derives the start order and cycle counts from the rules.
  task automatic run_frame(input logic [N-1:0] v, input bit inject,
                           output int len, output int plots, output int nst);
    logic [4:0] got_q[$];
    logic [4:0] exp_q[$];
    logic [4:0] cur_sel;
    logic [N-1:0] m;
    int exp_len, exp_plot, n, w, cyc, wk, stab, li;
    bit seen;
    exp_len = 2 * (N + 1) + 1;
    exp_plot = 0;
    n = 0;
    for (int p = 0; p < 2; p++) begin
      m = p ? v : prev_m;
      for (int i = 0; i < N; i++)
        if (m[i]) begin
          w = (lat_tab[n] > TO ? TO : lat_tab[n]) + 1;
          exp_len += 1 + w;
          exp_plot += w;
          if (lat_tab[n] > TO) exp_to = 1;
          exp_q.push_back({p == 0, 4'(i)});
          n++;
        end
    end
    if (inject) exp_ov = 1;
    @(negedge clk);
    frame_tick = 1'b1;
    obj_valid = v;
    @(negedge clk);
    frame_tick = 1'b0;
    cyc = 1;
    wk = 0;
    stab = 0;
    plots = 0;
    seen = 0;
    cur_sel = '0;
    while (cyc < 5000) begin
      if (cyc == 2) obj_valid = N'($urandom);
      if (obj_start) begin
        cur_sel = {erase, control_signal};
        got_q.push_back(cur_sel);
        wk = 0;
      end
      if (plot) begin
        plots++;
        if ({erase, control_signal} != cur_sel) stab++;
        li = got_q.size() > 0 ? got_q.size() - 1 : 0;
        li = li > 9 ? 9 : li;
        obj_done = (wk == lat_tab[li]);
        wk++;
      end else obj_done = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      frame_tick = inject && cyc == 3;
      if (frame_done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    frame_tick = 1'b0;
    obj_done = 1'b0;
    len = cyc;
    nst = got_q.size();
    chk("frame_done_seen", int'(seen), 1);
    chk("n_starts", nst, exp_q.size());
    for (int i = 0; i < nst && i < exp_q.size(); i++)
      chk($sformatf("start%0d_erase_idx", i), int'(got_q[i]), int'(exp_q[i]));
    chk("frame_len", len, exp_len);
    chk("plot_cycles", plots, exp_plot);
    chk("wait_sel_stable", stab, 0);
    chk("timeout_err", int'(timeout_err), int'(exp_to));
    chk("overrun", int'(overrun), int'(exp_ov));
    prev_m = v;
  endtask

  initial begin
    int len, plots, nst, k;
    logic [N-1:0] v;
    nvec = 0;
    nerr = 0;
    stray_en = 0;
    obj_valid = '0;
    tbl[0] = '{5'b00001, 3, 18, 1, 4};
    tbl[1] = '{5'b10011, 0, 21, 4, 4};
    tbl[2] = '{5'b00110, 1, 28, 5, 10};
    tbl[3] = '{5'b00000, 2, 21, 2, 6};
    tbl[4] = '{5'b11111, 5, 48, 5, 30};
    do_reset();
    chk("reset_outputs", int'({control_signal, obj_start, erase, plot, busy, frame_done, timeout_err, overrun}), 0);
    for (int t = 0; t < 5; t++) begin
      for (int j = 0; j < 10; j++) lat_tab[j] = tbl[t].lat;
      run_frame(tbl[t].valid, 0, len, plots, nst);
      chk($sformatf("tbl%0d_len", t), len, tbl[t].len);
      chk($sformatf("tbl%0d_starts", t), nst, tbl[t].starts);
      chk($sformatf("tbl%0d_plots", t), plots, tbl[t].plots);
    end
    // overrun tick mid-frame and stray obj_done outside WAIT
    stray_en = 1;
    for (int j = 0; j < 10; j++) lat_tab[j] = 2;
    run_frame(5'b01010, 1, len, plots, nst);
    stray_en = 0;
    @(negedge clk);
    obj_done = 1'b1;
    @(negedge clk);
    obj_done = 1'b0;
    chk("idle_stray_done_busy", int'(busy), 0);
    chk("idle_stray_done_sel", int'(control_signal), 0);
    // asynchronous reset in the middle of WAIT
    @(negedge clk);
    frame_tick = 1'b1;
    obj_valid = 5'b11111;
    @(negedge clk);
    frame_tick = 1'b0;
    k = 0;
    while (!plot && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("reached_wait", int'(plot), 1);
    #2 reset = 1'b0;
    #1;
    chk("midwait_reset_outputs", int'({control_signal, obj_start, erase, plot, busy, frame_done, timeout_err, overrun}), 0);
    @(negedge clk);
    chk("reset_held_no_frame_done", int'(frame_done), 0);
    reset = 1'b1;
    prev_m = '0;
    exp_to = 0;
    exp_ov = 0;
    for (int j = 0; j < 10; j++) lat_tab[j] = 1;
    run_frame(5'b00101, 0, len, plots, nst);
    // watchdog: draw of object 0 never completes, object 1 still drawn
    lat_tab = '{1, 1, 5000, 2, 0, 0, 0, 0, 0, 0};
    run_frame(5'b00011, 0, len, plots, nst);
    // done coincident with wdog == TIMEOUT
    do_reset();
    lat_tab[0] = TO;
    run_frame(5'b00001, 0, len, plots, nst);
    chk("coincident_plots", plots, TO + 1);
    // randomized frames
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 7) == 0) do_reset();
      v = N'($urandom);
      for (int j = 0; j < 10; j++) lat_tab[j] = $urandom_range(0, 6);
      stray_en = 1'($urandom_range(0, 1));
      run_frame(v, $urandom_range(0, 3) == 0, len, plots, nst);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
